vga_cmd_sched: RTL and testbench

VGA_CMD_SCHED -- requirements
Module: vga_cmd_sched

---
 rtl/vga_cmd_sched_pkg.sv | 29 ++
 rtl/vga_cmd_fifo.sv | 52 +++++
 rtl/vga_cmd_sched.sv | 148 ++++++++++++++
 tb/tb_vga_cmd_sched.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_cmd_sched_pkg.sv
// Shared encodings for the VGA display-command scheduler: command ops, FSM states and the
// packed command record that travels through the FIFO.
package vga_cmd_sched_pkg;

  localparam logic [1:0] OP_SPRITE_POS = 2'd0;
  localparam logic [1:0] OP_SPRITE_ATT = 2'd1;
  localparam logic [1:0] OP_BACKGROUND = 2'd2;
  localparam logic [1:0] OP_FONT_WR    = 2'd3;

  localparam int unsigned HOLD_CYC_DEFAULT = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StHold  = 2'd2,
    StGap   = 2'd3
  } state_e;

  typedef struct packed {
    logic [1:0]  op;
    logic [4:0]  sel;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        vis;
    logic [10:0] faddr;
    logic [3:0]  fdata;
  } cmd_t;

endpackage

// File: rtl/vga_cmd_fifo.sv
// Synchronous FIFO with occupancy count; Depth must be a power of two so pointers wrap
// naturally.
module vga_cmd_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == DepthCnt);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
      else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
    end
  end

  // Storage needs no reset: only entries below count_q are ever read out.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/vga_cmd_sched.sv
// Queues display-update commands and issues them one at a time during vertical blanking,
// strobing the matching load signal and holding data outputs stable until the next issue.
module vga_cmd_sched
  import vga_cmd_sched_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned HOLD_CYC   = HOLD_CYC_DEFAULT
) (
  input  logic                          clk_100mhz,
  input  logic                          rst_n,
  input  logic                          vblank_win,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [4:0]                    cmd_sel,
  input  logic [9:0]                    cmd_x,
  input  logic [8:0]                    cmd_y,
  input  logic                          cmd_vis,
  input  logic [10:0]                   cmd_faddr,
  input  logic [3:0]                    cmd_fdata,
  output logic [9:0]                    x,
  output logic [8:0]                    y,
  output logic [4:0]                    sprite_sel,
  output logic                          visable,
  output logic                          load_pos,
  output logic                          load_att,
  output logic                          bchange_active,
  output logic [1:0]                    background_sel,
  output logic [10:0]                   fwaddr,
  output logic [3:0]                    fwdata,
  output logic                          fwenable,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CntW = $clog2(HOLD_CYC + 1);
  localparam logic [CntW-1:0] HoldMax = CntW'(HOLD_CYC);

  state_e          state_q, state_d;
  logic [CntW-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]      sync_q;
  logic            run;
  cmd_t            cur_q, head, push_data;
  logic            fifo_full, fifo_empty, pop, start;

  // Reset assertion is asynchronous; release takes two edges before the FSM may move.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], 1'b1};
  end
  assign run = sync_q[1];

  assign push_data = '{op: cmd_op, sel: cmd_sel, x: cmd_x, y: cmd_y, vis: cmd_vis,
                       faddr: cmd_faddr, fdata: cmd_fdata};
  assign cmd_ready = !fifo_full;

  vga_cmd_fifo #(
    .Depth (FIFO_DEPTH),
    .Width ($bits(cmd_t))
  ) u_fifo (
    .clk_i   (clk_100mhz),
    .rst_ni  (rst_n),
    .push_i  (cmd_valid && cmd_ready),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign start = run && !fifo_empty && vblank_win;

  // GAP folds in the IDLE decision so back-to-back commands issue every other cycle.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    pop        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StIssue;
          pop     = 1'b1;
        end
      end
      StIssue: begin
        if (cur_q.op == OP_BACKGROUND && HOLD_CYC > 1) begin
          state_d    = StHold;
          hold_cnt_d = CntW'(2);
        end else begin
          state_d = StGap;
        end
      end
      StHold: begin
        if (hold_cnt_q >= HoldMax) state_d = StGap;
        else                       hold_cnt_d = hold_cnt_q + 1'b1;
      end
      StGap: begin
        if (start) begin
          state_d = StIssue;
          pop     = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n)   cur_q <= '0;
    else if (pop) cur_q <= head;
  end

  always_comb begin
    load_pos       = 1'b0;
    load_att       = 1'b0;
    fwenable       = 1'b0;
    bchange_active = (state_q == StHold);
    if (state_q == StIssue) begin
      unique case (cur_q.op)
        OP_SPRITE_POS: load_pos       = 1'b1;
        OP_SPRITE_ATT: load_att       = 1'b1;
        OP_BACKGROUND: bchange_active = 1'b1;
        OP_FONT_WR:    fwenable       = 1'b1;
      endcase
    end
  end

  assign busy           = (state_q != StIdle);
  assign x              = cur_q.x;
  assign y              = cur_q.y;
  assign sprite_sel     = cur_q.sel;
  assign visable        = cur_q.vis;
  assign background_sel = cur_q.sel[1:0];
  assign fwaddr         = cur_q.faddr;
  assign fwdata         = cur_q.fdata;

endmodule

// File: tb/tb_vga_cmd_sched.sv
// Self-checking bench for vga_cmd_sched: directed vector table, corner-case sequences and a
// randomized run, all compared every cycle against a queue-based reference model.
module tb_vga_cmd_sched;

  localparam int DEPTH = 4;
  localparam int HOLD  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vblank_win, cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_sel;
  logic [9:0]  cmd_x;
  logic [8:0]  cmd_y;
  logic        cmd_vis;
  logic [10:0] cmd_faddr;
  logic [3:0]  cmd_fdata;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [4:0]  sprite_sel;
  logic        visable, load_pos, load_att, bchange_active, fwenable, busy;
  logic [1:0]  background_sel;
  logic [10:0] fwaddr;
  logic [3:0]  fwdata;
  logic [2:0]  fifo_count;

  vga_cmd_sched #(.FIFO_DEPTH(DEPTH), .HOLD_CYC(HOLD)) dut (
    .clk_100mhz(clk), .rst_n(rst_n), .vblank_win(vblank_win), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_sel(cmd_sel), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .cmd_vis(cmd_vis), .cmd_faddr(cmd_faddr), .cmd_fdata(cmd_fdata), .x(x), .y(y),
    .sprite_sel(sprite_sel), .visable(visable), .load_pos(load_pos), .load_att(load_att),
    .bchange_active(bchange_active), .background_sel(background_sel), .fwaddr(fwaddr),
    .fwdata(fwdata), .fwenable(fwenable), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit [1:0]  op;
    bit [4:0]  sel;
    bit [9:0]  x;
    bit [8:0]  y;
    bit        vis;
    bit [10:0] faddr;
    bit [3:0]  fdata;
  } cmd_s;

  typedef struct {
    cmd_s c;
    int   npos, natt, nbg, nfw;
  } vec_s;

  // Reference model: pending queue, last issued command, cycles left in its slot.
  cmd_s mq[$];
  cmd_s mcur;
  int   rem;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cmd_s mk(bit [1:0] op, bit [4:0] sel, bit [9:0] cx, bit [8:0] cy,
                              bit vis, bit [10:0] fa, bit [3:0] fd);
    cmd_s c;
    c.op = op; c.sel = sel; c.x = cx; c.y = cy; c.vis = vis; c.faddr = fa; c.fdata = fd;
    return c;
  endfunction

  function automatic cmd_s rand_cmd();
    return mk(2'($urandom), 5'($urandom), 10'($urandom), 9'($urandom), 1'($urandom),
              11'($urandom), 4'($urandom));
  endfunction

  function automatic vec_s mkvec(cmd_s c, int p, int a, int b, int f);
    vec_s v;
    v.c = c; v.npos = p; v.natt = a; v.nbg = b; v.nfw = f;
    return v;
  endfunction

  function automatic logic [41:0] data_of(cmd_s c);
    return {c.x, c.y, c.sel, c.vis, c.sel[1:0], c.faddr, c.fdata};
  endfunction

  task automatic model_reset();
    mq.delete();
    rem  = 0;
    mcur = mk(0, 0, 0, 0, 0, 0, 0);
  endtask

  // One rising edge: a pop needs a non-empty queue before this edge, an open blanking
  // window and an idle or finishing slot; the push lands after the pop.
  task automatic model_edge();
    int   sz;
    cmd_s pushed;
    sz = mq.size();
    pushed = mk(cmd_op, cmd_sel, cmd_x, cmd_y, cmd_vis, cmd_faddr, cmd_fdata);
    if (sz > 0 && vblank_win && rem <= 1) begin
      mcur = mq.pop_front();
      rem  = (mcur.op == 2'd2) ? HOLD + 1 : 2;
    end else if (rem > 0) begin
      rem--;
    end
    if (cmd_valid && sz < DEPTH) mq.push_back(pushed);
  endtask

  task automatic check_outputs();
    bit active;
    active = (rem > 1);
    chk("strobes", {load_pos, load_att, fwenable, bchange_active, busy},
        {active && mcur.op == 2'd0, active && mcur.op == 2'd1, active && mcur.op == 2'd3,
         active && mcur.op == 2'd2, rem > 0});
    chk("data", {x, y, sprite_sel, visable, background_sel, fwaddr, fwdata}, data_of(mcur));
    chk("fifo", {cmd_ready, fifo_count}, {mq.size() < DEPTH, 3'(mq.size())});
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge();
    #1;
    check_outputs();
  endtask

  task automatic set_cmd(cmd_s c);
    cmd_op = c.op; cmd_sel = c.sel; cmd_x = c.x; cmd_y = c.y; cmd_vis = c.vis;
    cmd_faddr = c.faddr; cmd_fdata = c.fdata;
  endtask

  task automatic push_cmd(cmd_s c);
    set_cmd(c);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  vec_s vt[5];
  cmd_s fcmd;
  int   npos, natt, nbg, nfw, nstrobe;

  initial begin
    vt[0] = mkvec(mk(2'd0, 5'd3, 10'd100, 9'd50, 1'b1, 11'd0, 4'd0), 1, 0, 0, 0);
    vt[1] = mkvec(mk(2'd2, 5'd2, 10'd7, 9'd8, 1'b0, 11'd9, 4'd1), 0, 0, HOLD, 0);
    vt[2] = mkvec(mk(2'd1, 5'd17, 10'd1023, 9'd511, 1'b0, 11'd3, 4'd2), 0, 1, 0, 0);
    vt[3] = mkvec(mk(2'd3, 5'd9, 10'd0, 9'd1, 1'b1, 11'h5A5, 4'd9), 0, 0, 0, 1);
    vt[4] = mkvec(mk(2'd2, 5'd13, 10'd512, 9'd256, 1'b1, 11'h7FF, 4'hF), 0, 0, HOLD, 0);

    rst_n = 1'b0; vblank_win = 1'b0; cmd_valid = 1'b0;
    set_cmd(mk(0, 0, 0, 0, 0, 0, 0));
    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step();

    // Directed table: each command issued alone with the window open.
    vblank_win = 1'b1;
    foreach (vt[i]) begin
      push_cmd(vt[i].c);
      npos = 0; natt = 0; nbg = 0; nfw = 0;
      for (int k = 0; k < 8; k++) begin
        step();
        npos += int'(load_pos); natt += int'(load_att);
        nbg  += int'(bchange_active); nfw += int'(fwenable);
      end
      chk($sformatf("vec%0d_counts", i), {8'(npos), 8'(natt), 8'(nbg), 8'(nfw)},
          {8'(vt[i].npos), 8'(vt[i].natt), 8'(vt[i].nbg), 8'(vt[i].nfw)});
      chk($sformatf("vec%0d_data", i), {x, y, sprite_sel, visable, background_sel, fwaddr,
          fwdata}, data_of(vt[i].c));
    end

    // Window closed: five pushes, only four fit, nothing issues until it opens.
    vblank_win = 1'b0;
    for (int k = 0; k < 5; k++) push_cmd(rand_cmd());
    chk("full_count_ready", {cmd_ready, fifo_count}, {1'b0, 3'd4});
    vblank_win = 1'b1;
    repeat (20) step();
    chk("drained", fifo_count, 3'd0);

    // Simultaneous push and pop at occupancy two.
    vblank_win = 1'b0;
    push_cmd(rand_cmd());
    push_cmd(rand_cmd());
    vblank_win = 1'b1;
    push_cmd(rand_cmd());
    chk("push_pop_count", fifo_count, 3'd2);
    repeat (20) step();

    // Window drops during background hold: hold completes, queued font write waits.
    fcmd = mk(2'd3, 5'd4, 10'd0, 9'd0, 1'b0, 11'h2C3, 4'd6);
    push_cmd(mk(2'd2, 5'd1, 10'd0, 9'd0, 1'b0, 11'd0, 4'd0));
    push_cmd(fcmd);
    step();
    vblank_win = 1'b0;
    nbg = 2; nfw = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      nbg += int'(bchange_active); nfw += int'(fwenable);
    end
    chk("hold_completes", 8'(nbg), 8'(HOLD));
    chk("font_waits", 8'(nfw), 8'd0);
    vblank_win = 1'b1;
    nfw = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      nfw += int'(fwenable);
    end
    chk("font_issued", {8'(nfw), fwaddr, fwdata}, {8'd1, fcmd.faddr, fcmd.fdata});

    // Asynchronous reset mid-hold with three commands queued.
    vblank_win = 1'b0;
    push_cmd(mk(2'd2, 5'd3, 10'd5, 9'd5, 1'b1, 11'd5, 4'd5));
    for (int k = 0; k < 3; k++) push_cmd(rand_cmd());
    vblank_win = 1'b1;
    step();
    step();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("async_reset", {bchange_active, busy, cmd_ready, fifo_count, x}, {3'b001, 3'd0, 10'd0});
    step();
    @(negedge clk);
    rst_n = 1'b1;
    nstrobe = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      nstrobe += int'(load_pos) + int'(load_att) + int'(fwenable) + int'(bchange_active);
    end
    chk("no_strobe_after_reset", 8'(nstrobe), 8'd0);

    // Randomized traffic with a toggling blanking window.
    for (int k = 0; k < 800; k++) begin
      set_cmd(rand_cmd());
      cmd_valid = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) vblank_win = ~vblank_win;
      step();
    end
    cmd_valid  = 1'b0;
    vblank_win = 1'b1;
    repeat (40) step();
    chk("final_empty", {busy, fifo_count}, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
